i2c_slave_bit_shift: RTL
========================

# i2c_slave_bit_shift

I2C target-side (slave) byte engine: the responder counterpart to our I2C master bit-shift block, used to emulate the SD30xx RTC on the bus for loopback verification and to expose FPGA registers to an external I2C master. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, then receives write bytes or transmits read bytes through a simple byte handshake. No clock stretching; SDA is driven open-drain.

## Interface
Parameters:
- SLAVE_ADDR, 7'h32, 7-bit bus address this target answers to.
- FILT_LEN, 3, glitch-filter length in clk cycles (used only with the macro below).

Ports:
- clk  input  1  system clock (≥ 20× SCL rate).
- rst  input  1  asynchronous, active-high reset.
- i2c_sclk  input  1  bus SCL (never driven by this block).
- i2c_sdat  inout  1  bus SDA; driven 0 or released to 'z' only.
- tx_data  input  8  byte to return on a read; sampled when a byte starts.
- tx_req  output  1  one-clk pulse: present next tx_data.
- rx_data  output  8  last received write byte.
- rx_valid  output  1  one-clk pulse: rx_data updated.
- rx_first  output  1  high with rx_valid for the first data byte after the address (register pointer).
- rw_o  output  1  R/W bit of the last matched address (1 = read).
- busy  output  1  high from address match until STOP or non-match.
- nack_o  output  1  one-clk pulse when master NACKs a read byte.

Reset values: rx_data 8'h00; tx_req, rx_valid, rx_first, rw_o, busy, nack_o 0; SDA released.

## Operation
- Input path: 2-flop synchronizer on SCL and SDA, then previous-value register; scl_rise, scl_fall, start (SDA 1→0 while SCL high), stop (SDA 0→1 while SCL high) derived from synchronized signals.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE: waits for start → ADDR, bit counter cleared.
- ADDR: shift SDA MSB-first on each scl_rise; after 8th bit compare [7:1] with SLAVE_ADDR. Match → ADDR_ACK, rw_o ← bit0, busy 1. No match → WAIT_STOP.
- ADDR_ACK: on next scl_fall drive SDA 0; hold through ACK high; on following scl_fall → RD_BYTE (rw_o=1, driving tx_data[7]) or release SDA → WR_BYTE.
- WR_BYTE: 8 samples on scl_rise; after 8th, rx_data updated, rx_valid pulses (rx_first set if first byte of transaction) → WR_ACK; ACK driven as in ADDR_ACK; loop back to WR_BYTE.
- RD_BYTE: tx_data latched into shift register on entry scl_fall; bit n driven 0/released on each scl_fall; after 8th bit's scl_fall SDA released → RD_ACK.
- RD_ACK: sample SDA on scl_rise; 0 (ACK) → tx_req pulse, next scl_fall → RD_BYTE; 1 (NACK) → nack_o pulse → WAIT_STOP.
- WAIT_STOP: SDA released; waits for start or stop.
- start in any state (repeated START) → ADDR, SDA released, rx_first re-armed; stop in any state → IDLE, SDA released, busy 0. stop beats start (impossible together on one edge; stop checked first).

## Timing
- Detection latency: 2 clk from pin change to edge/condition flags (+FILT_LEN with filter).
- SDA drive changes 1 clk after detected scl_fall; never changes while SCL high except release on stop/start.
- tx_req pulses at address-ACK scl_rise (read) and at master-ACK scl_rise; tx_data must be stable by the next scl_fall (half SCL period).
- rx_valid pulses 1 clk after the 8th data scl_rise.
- Reset mid-transfer: SDA released in same cycle (async), state IDLE; mid-byte bus activity ignored until next START.

## Configuration
- I2C_SLAVE_GLITCH_FILTER_EN defined: SCL and SDA each pass a FILT_LEN-cycle consensus filter after the synchronizer (output changes only after FILT_LEN identical samples); spikes shorter than FILT_LEN clk are rejected.
- Undefined: synchronizer only; any 1-clk pulse is treated as an edge.

## Test plan
- Write: START, 0x64 (0x32+W), 0x05, 0xA7, STOP -> ACK on all three bytes; rx_valid twice with rx_data 0x05 (rx_first=1) then 0xA7 (rx_first=0); busy 0 after STOP.
- Read: START, 0x65, tx_data 0x3C then 0x81, master ACK then NACK, STOP -> bus bytes 0x3C, 0x81; tx_req pulses twice; nack_o pulses once.
- Address mismatch: START, 0xA0 -> SDA released at ACK slot (NACK); no rx_valid; busy stays 0.
- Repeated START: write 0x64,0x10 then Sr, 0x65 read -> rx_data 0x10 rx_first=1, rw_o=1, first tx byte transmitted.
- Reset asserted during RD_BYTE with SDA driven 0 -> SDA 'z' immediately, all outputs at reset values, next START 0x64 ACKed.
- With I2C_SLAVE_GLITCH_FILTER_EN, FILT_LEN=3: 2-clk SCL spike mid-bit -> no extra bit shifted; 0x64 still ACKed.

Source files
------------

// File: rtl/i2c_slave_bit_shift.sv
// rtl/i2c_slave_bit_shift.sv - I2C target byte engine: START/STOP detect, 7-bit address match, ACK, byte rx/tx.
// Optional SCL/SDA consensus glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_bit_shift #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h32,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       rw_o,
    output logic       busy,
    output logic       nack_o
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WR_BYTE   = 3'd3;
    localparam logic [2:0] WR_ACK    = 3'd4;
    localparam logic [2:0] RD_BYTE   = 3'd5;
    localparam logic [2:0] RD_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned FILT_EFF = FILT_LEN;
`else
    // Filter bypassed; the length parameter stays on the interface for drop-in builds.
    localparam int unsigned FILT_EFF = 1 + 0 * FILT_LEN;
`endif

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_c, sda_c;
    logic       scl_prev_q, sda_prev_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], i2c_sclk};
        sda_sync_d = {sda_sync_q[0], i2c_sdat};
    end

    generate
        if (FILT_EFF > 1) begin : g_filt
            localparam int unsigned CW = $clog2(FILT_EFF);
            logic [1:0]         raw;
            logic [1:0]         filt_q, filt_d;
            logic [1:0][CW-1:0] cnt_q, cnt_d;

            assign raw = {scl_sync_q[1], sda_sync_q[1]};

            // Output follows the input only after FILT_EFF consecutive differing samples.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = cnt_q;
                for (int i = 0; i < 2; i++) begin
                    if (raw[i] != filt_q[i]) begin
                        if (cnt_q[i] == CW'(FILT_EFF - 1)) begin
                            filt_d[i] = raw[i];
                            cnt_d[i]  = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    filt_q <= 2'b11;
                    cnt_q  <= '0;
                end else begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign scl_c = filt_q[1];
            assign sda_c = filt_q[0];
        end else begin : g_nofilt
            assign scl_c = scl_sync_q[1];
            assign sda_c = sda_sync_q[1];
        end
    endgenerate

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c & scl_prev_q;
    assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       first_pend_q, first_pend_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       tx_req_q, tx_req_d;
    logic       nack_q, nack_d;
    logic       phase_q, phase_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_first_d   = 1'b0;
        first_pend_d = first_pend_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        tx_req_d     = 1'b0;
        nack_d       = 1'b0;
        phase_d      = phase_q;

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d      = ADDR;
            sda_oe_d     = 1'b0;
            bit_cnt_d    = 4'd0;
            first_pend_d = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_c};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = sda_c;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    // phase 0: wait for the fall that opens the ACK slot; phase 1: hold ACK low.
                    if (!phase_q) begin
                        if (scl_fall) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end
                    end else begin
                        if (scl_rise && state_q == ADDR_ACK && rw_q) begin
                            tx_req_d = 1'b1;
                        end
                        if (scl_fall) begin
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_d   = RD_BYTE;
                                shift_d   = {tx_data[6:0], 1'b0};
                                sda_oe_d  = ~tx_data[7];
                                bit_cnt_d = 4'd1;
                            end else begin
                                state_d   = WR_BYTE;
                                sda_oe_d  = 1'b0;
                                bit_cnt_d = 4'd0;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_c};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d    = {shift_q[6:0], sda_c};
                            rx_valid_d   = 1'b1;
                            rx_first_d   = first_pend_q;
                            first_pend_d = 1'b0;
                            state_d      = WR_ACK;
                            phase_d      = 1'b0;
                            bit_cnt_d    = 4'd0;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            state_d   = RD_ACK;
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (!phase_q) begin
                        if (scl_rise) begin
                            if (!sda_c) begin
                                tx_req_d = 1'b1;
                                phase_d  = 1'b1;
                            end else begin
                                nack_d  = 1'b1;
                                state_d = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall) begin
                        state_d   = RD_BYTE;
                        shift_d   = {tx_data[6:0], 1'b0};
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = 4'd1;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q   <= 2'b11;
            sda_sync_q   <= 2'b11;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            first_pend_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            tx_req_q     <= 1'b0;
            nack_q       <= 1'b0;
            phase_q      <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_c;
            sda_prev_q   <= sda_c;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            first_pend_q <= first_pend_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            tx_req_q     <= tx_req_d;
            nack_q       <= nack_d;
            phase_q      <= phase_d;
        end
    end

    assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
    assign tx_req   = tx_req_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign rw_o     = rw_q;
    assign busy     = busy_q;
    assign nack_o   = nack_q;

endmodule
